fft4_stream_engine: RTL and testbench
=====================================

Name: fft4_stream_engine

Overview:
- Parametrised, handshaked successor to the combinational 4-point FFT engine.
- Accepts one complex sample per beat over a valid/ready stream, buffers a 4-sample frame, computes the forward or inverse 4-point DFT, then streams the 4 bins out in natural order under valid/ready backpressure.
- Supports selectable output scaling with saturation reporting.
- Sits between the sample front-end and the spectral post-processing stage.

Parameters:
- DATA_W, 8, signed width of each real/imag component on input and output (legal 4..16).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  engine can accept an input sample.
- in_real  in  DATA_W  signed real part of input sample.
- in_imag  in  DATA_W  signed imag part of input sample.
- inverse  in  1  1 = inverse DFT (conjugate twiddles); sampled with frame sample 0.
- scale  in  1  1 = divide outputs by 4; 0 = unscaled with saturation; sampled with frame sample 0.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts output bin.
- out_real  out  DATA_W  signed real part of output bin.
- out_imag  out  DATA_W  signed imag part of output bin.
- out_index  out  2  bin number 0..3 of current output.
- out_last  out  1  high with bin 3.
- out_sat  out  1  current bin was clamped (real or imag).

Behaviour:
- Reset (rst low, async): state=LOAD, sample count=0, all outputs 0 including in_ready. The buffered frame is discarded.
- First rising edge after reset release sets in_ready=1.
- FSM states: LOAD, COMPUTE, UNLOAD. All outputs are registered.
- LOAD:
  - A sample is accepted on an edge with in_valid && in_ready; it is stored at x[count], and count increments.
  - inverse and scale are latched on the edge accepting sample 0.
  - Gaps in in_valid are allowed.
  - The edge accepting sample 3 sets in_ready<=0 and moves to COMPUTE.
- COMPUTE (exactly 1 cycle):
  - Computes all 4 bins at internal width DATA_W+2 and stores them in a result buffer.
  - On exit: out_valid<=1, out_index<=0, outputs loaded with bin 0; moves to UNLOAD.
- Latency: bin 0 is visible the cycle after the edge following acceptance of sample 3 (2 edges).
- Math, forward (a=x0+x2, b=x0-x2, c=x1+x3, d=x1-x3):
  - X0 = a+c
  - X2 = a-c
  - X1 = b - j·d
  - X3 = b + j·d
  - inverse=1 swaps the j signs: X1 = b + j·d, X3 = b - j·d.
  - No 1/N normalisation beyond the scale option.
- scale=1: result >>> 2 (arithmetic shift, floor). This always fits DATA_W, so out_sat=0.
- scale=0: each component is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. out_sat=1 if either component of that bin clamped.
- UNLOAD:
  - On an edge with out_valid && out_ready: if out_index<3, advance to the next bin; if out_index==3, set out_valid<=0, state<=LOAD, in_ready<=1.
  - out_last = (out_index==3) while out_valid.
  - While out_valid && !out_ready, all out_* remain stable.
- No frame overlap: in_ready=0 throughout COMPUTE and UNLOAD. The minimum frame period is 9 cycles.
- inverse/scale changes mid-frame have no effect on the current frame.
- Reset mid-operation returns to the reset state immediately; the next frame after release is processed correctly.

Test Plan:
- Impulse: DATA_W=8, fwd, scale=0, x=[(10,0),(0,0),(0,0),(0,0)], out_ready=1 → bins 0..3 all (10,0), out_sat=0, out_last only on bin 3, bin 0 appears 2 edges after the 4th accept.
- Shifted impulse: x=[(0,0),(10,0),(0,0),(0,0)]:
  - fwd → (10,0),(0,-10),(-10,0),(0,10)
  - inverse=1 → (10,0),(0,10),(-10,0),(0,-10)
- Saturation/scale:
  - all (100,0), scale=0 → X0=(127,0) out_sat=1, others (0,0) out_sat=0
  - all (100,0), scale=1 → X0=(100,0)
  - all (-128,0), scale=1 → X0=(-128,0)
- Backpressure: hold out_ready=0 for 3 cycles while out_index=1 → out_real/out_imag/out_index held; in_ready stays 0 with in_valid=1; no sample consumed; sequence then completes and in_ready returns to 1.
- Input gaps and mode latch: in_valid toggled 1,0,1,0… with inverse toggled after sample 0 → results identical to the contiguous frame using the sample-0 inverse value.
- Reset mid-UNLOAD (after bin 1): all outputs 0 asynchronously; after release, in_ready=1 after 1 edge; next DC frame all (20,0) → X0=(80,0), others (0,0).

Source files
------------

// File: rtl/fft4_stream_engine.sv
`default_nettype none
// ============================================================================
// fft4_stream_engine : buffers a 4-sample complex frame from a valid/ready
// stream, computes its forward or inverse 4-point DFT and streams bins 0..3 out.
// Rev 1.0
// ============================================================================
module fft4_stream_engine #(
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    input  logic                     inverse,
    input  logic                     scale,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_real,
    output logic signed [DATA_W-1:0] out_imag,
    output logic [1:0]               out_index,
    output logic                     out_last,
    output logic                     out_sat
);
    localparam int IW = DATA_W + 2;
    localparam logic signed [IW-1:0] C_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [IW-1:0] C_MIN = {3'b111, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_UNLOAD  = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 count_q, count_d;
    logic                       inv_q, inv_d, scale_q, scale_d;
    logic signed [DATA_W-1:0]   xr_q [4], xr_d [4], xi_q [4], xi_d [4];
    logic signed [DATA_W-1:0]   res_re_q [4], res_re_d [4], res_im_q [4], res_im_d [4];
    logic [3:0]                 res_sat_q, res_sat_d;
    logic                       in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]   out_real_q, out_real_d, out_imag_q, out_imag_d;
    logic [1:0]                 out_index_q, out_index_d;
    logic                       out_last_q, out_last_d, out_sat_q, out_sat_d;

    logic signed [IW-1:0]       ar, ai, br, bi, cr, ci, dr, di;
    logic signed [IW-1:0]       bin_re [4], bin_im [4];
    logic signed [DATA_W-1:0]   cv_re [4], cv_im [4];
    logic [3:0]                 cv_sat;
    logic [1:0]                 next_idx;

    // Scaled values always fit, so the shift is a plain bit-slice of the wide result.
    function automatic logic [DATA_W:0] conv(input logic signed [IW-1:0] v, input logic sc);
        if (sc)             conv = {1'b0, v[DATA_W+1:2]};
        else if (v > C_MAX) conv = {1'b1, C_MAX[DATA_W-1:0]};
        else if (v < C_MIN) conv = {1'b1, C_MIN[DATA_W-1:0]};
        else                conv = {1'b0, v[DATA_W-1:0]};
    endfunction

    always_comb begin
        ar = IW'(xr_q[0]) + IW'(xr_q[2]);
        ai = IW'(xi_q[0]) + IW'(xi_q[2]);
        br = IW'(xr_q[0]) - IW'(xr_q[2]);
        bi = IW'(xi_q[0]) - IW'(xi_q[2]);
        cr = IW'(xr_q[1]) + IW'(xr_q[3]);
        ci = IW'(xi_q[1]) + IW'(xi_q[3]);
        dr = IW'(xr_q[1]) - IW'(xr_q[3]);
        di = IW'(xi_q[1]) - IW'(xi_q[3]);
        bin_re[0] = ar + cr;
        bin_im[0] = ai + ci;
        bin_re[2] = ar - cr;
        bin_im[2] = ai - ci;
        // -j*d = (di, -dr); the inverse transform swaps which bin gets it
        if (inv_q) begin
            bin_re[1] = br - di;
            bin_im[1] = bi + dr;
            bin_re[3] = br + di;
            bin_im[3] = bi - dr;
        end else begin
            bin_re[1] = br + di;
            bin_im[1] = bi - dr;
            bin_re[3] = br - di;
            bin_im[3] = bi + dr;
        end
    end

    always_comb begin
        logic [DATA_W:0] tr, ti;
        for (int k = 0; k < 4; k++) begin
            tr        = conv(bin_re[k], scale_q);
            ti        = conv(bin_im[k], scale_q);
            cv_re[k]  = tr[DATA_W-1:0];
            cv_im[k]  = ti[DATA_W-1:0];
            cv_sat[k] = tr[DATA_W] | ti[DATA_W];
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        inv_d       = inv_q;
        scale_d     = scale_q;
        xr_d        = xr_q;
        xi_d        = xi_q;
        res_re_d    = res_re_q;
        res_im_d    = res_im_q;
        res_sat_d   = res_sat_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_real_d  = out_real_q;
        out_imag_d  = out_imag_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_sat_d   = out_sat_q;
        next_idx    = out_index_q + 2'd1;

        case (state_q)
            S_LOAD: begin
                if (!in_ready_q) begin
                    in_ready_d = 1'b1;
                end else if (in_valid) begin
                    xr_d[count_q] = in_real;
                    xi_d[count_q] = in_imag;
                    if (count_q == 2'd0) begin
                        inv_d   = inverse;
                        scale_d = scale;
                    end
                    count_d = count_q + 2'd1;
                    if (count_q == 2'd3) begin
                        in_ready_d = 1'b0;
                        state_d    = S_COMPUTE;
                    end
                end
            end
            S_COMPUTE: begin
                res_re_d    = cv_re;
                res_im_d    = cv_im;
                res_sat_d   = cv_sat;
                out_valid_d = 1'b1;
                out_index_d = 2'd0;
                out_real_d  = cv_re[0];
                out_imag_d  = cv_im[0];
                out_sat_d   = cv_sat[0];
                out_last_d  = 1'b0;
                state_d     = S_UNLOAD;
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (out_index_q != 2'd3) begin
                        out_index_d = next_idx;
                        out_real_d  = res_re_q[next_idx];
                        out_imag_d  = res_im_q[next_idx];
                        out_sat_d   = res_sat_q[next_idx];
                        out_last_d  = (next_idx == 2'd3);
                    end else begin
                        out_valid_d = 1'b0;
                        out_index_d = 2'd0;
                        out_real_d  = '0;
                        out_imag_d  = '0;
                        out_sat_d   = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = S_LOAD;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            count_q     <= 2'd0;
            inv_q       <= 1'b0;
            scale_q     <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                xr_q[k]     <= '0;
                xi_q[k]     <= '0;
                res_re_q[k] <= '0;
                res_im_q[k] <= '0;
            end
            res_sat_q   <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_real_q  <= '0;
            out_imag_q  <= '0;
            out_index_q <= 2'd0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            inv_q       <= inv_d;
            scale_q     <= scale_d;
            xr_q        <= xr_d;
            xi_q        <= xi_d;
            res_re_q    <= res_re_d;
            res_im_q    <= res_im_d;
            res_sat_q   <= res_sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_real_q  <= out_real_d;
            out_imag_q  <= out_imag_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_fft4_stream_engine.sv
`default_nettype none
// ============================================================================
// tb_fft4_stream_engine : scoreboard bench with a direct-DFT reference model.
// Rev 1.0
// ============================================================================
module tb_fft4_stream_engine;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic inverse = 1'b0;
    logic scale = 1'b0;
    logic signed [DATA_W-1:0] in_real = '0;
    logic signed [DATA_W-1:0] in_imag = '0;
    logic in_ready, out_valid, out_last, out_sat;
    logic signed [DATA_W-1:0] out_real, out_imag;
    logic [1:0] out_index;
    logic bp_en = 1'b0;
    logic bp_val = 1'b1;
    logic bp_rand = 1'b1;
    wire  out_ready = bp_en ? bp_rand : bp_val;

    typedef struct {
        int re;
        int im;
        int idx;
        int last;
        int sat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   fr_re[4];
    int   fr_im[4];

    fft4_stream_engine #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag),
        .inverse(inverse), .scale(scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_real(out_real), .out_imag(out_imag),
        .out_index(out_index), .out_last(out_last), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        bp_rand = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    // Reference: direct 4-point DFT sum with twiddle (-j)^(n*k), conjugated for inverse.
    task automatic push_frame(input bit inv, input bit sc);
        int   sr, si, m, lim;
        exp_t e;
        lim = 1 << (DATA_W - 1);
        for (int k = 0; k < 4; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 4; n++) begin
                m = (n * k) % 4;
                if (inv) m = (4 - m) % 4;
                case (m)
                    0: begin sr += fr_re[n]; si += fr_im[n]; end
                    1: begin sr += fr_im[n]; si -= fr_re[n]; end
                    2: begin sr -= fr_re[n]; si -= fr_im[n]; end
                    default: begin sr -= fr_im[n]; si += fr_re[n]; end
                endcase
            end
            e.idx  = k;
            e.last = (k == 3);
            e.sat  = 0;
            if (sc) begin
                e.re = sr >>> 2;
                e.im = si >>> 2;
            end else begin
                e.re = sr;
                e.im = si;
                if (sr > lim - 1) begin e.re = lim - 1; e.sat = 1; end
                if (sr < -lim)    begin e.re = -lim;    e.sat = 1; end
                if (si > lim - 1) begin e.im = lim - 1; e.sat = 1; end
                if (si < -lim)    begin e.im = -lim;    e.sat = 1; end
            end
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input bit inv, input bit sc, input int max_gap, input bit toggle);
        int g;
        push_frame(inv, sc);
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b0;
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_real  = fr_re[n][DATA_W-1:0];
            in_imag  = fr_im[n][DATA_W-1:0];
            if (n == 0) begin
                inverse = inv;
                scale   = sc;
            end else if (toggle) begin
                inverse = ~inverse;
                scale   = ~scale;
            end
            g = 0;
            while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
            if (g >= 100) chk("in_ready_timeout", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!out_valid && g < 50) begin @(posedge clk); #1; g++; end
        if (g >= 50) chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((sb.size() != 0 || out_valid) && g < 300) begin @(posedge clk); #1; g++; end
        if (g >= 300) chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic set_frame(input int r0, input int r1, input int r2, input int r3,
                             input int i0, input int i1, input int i2, input int i3);
        fr_re[0] = r0; fr_re[1] = r1; fr_re[2] = r2; fr_re[3] = r3;
        fr_im[0] = i0; fr_im[1] = i1; fr_im[2] = i2; fr_im[3] = i3;
    endtask

    task automatic rand_frame();
        for (int n = 0; n < 4; n++) begin
            fr_re[n] = int'($urandom_range(0, 255)) - 128;
            fr_im[n] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_output_bin", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("bin_real", out_real, e.re);
                chk("bin_imag", out_imag, e.im);
                chk("bin_index", out_index, e.idx);
                chk("bin_last", out_last, e.last);
                chk("bin_sat", out_sat, e.sat);
            end
        end
    end

    initial begin
        int hr, hi;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_real", out_real, 0);
        chk("rst_out_imag", out_imag, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_sat", out_sat, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_release", in_ready, 1);

        // impulse, with the two-edge latency observed directly
        set_frame(10, 0, 0, 0, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0, 0, 1'b0);
        chk("compute_cycle_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_out_valid", out_valid, 1);
        chk("latency_out_index", out_index, 0);
        wait_idle();

        set_frame(0, 10, 0, 0, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0, 0, 1'b0);
        wait_idle();
        send_frame(1'b1, 1'b0, 0, 1'b0);
        wait_idle();

        set_frame(100, 100, 100, 100, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0, 0, 1'b0);
        wait_idle();
        send_frame(1'b0, 1'b1, 0, 1'b0);
        wait_idle();
        set_frame(-128, -128, -128, -128, 0, 0, 0, 0);
        send_frame(1'b0, 1'b1, 0, 1'b0);
        wait_idle();
        send_frame(1'b0, 1'b0, 0, 1'b0);
        wait_idle();

        // backpressure held on bin 1
        bp_val = 1'b0;
        set_frame(7, -3, 25, 90, -40, 11, 0, -128);
        send_frame(1'b0, 1'b0, 0, 1'b0);
        wait_valid();
        bp_val = 1'b1;
        @(posedge clk);
        #1;
        bp_val = 1'b0;
        chk("bp_index_before_hold", out_index, 1);
        hr = out_real;
        hi = out_imag;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_hold_real", out_real, hr);
            chk("bp_hold_imag", out_imag, hi);
            chk("bp_hold_index", out_index, 1);
            chk("bp_in_ready_low", in_ready, 0);
        end
        in_valid = 1'b0;
        bp_val = 1'b1;
        wait_idle();
        chk("bp_in_ready_returns", in_ready, 1);

        // gaps with mode inputs toggling after sample 0
        set_frame(33, -70, 12, 5, 8, 60, -90, 127);
        send_frame(1'b1, 1'b0, 3, 1'b1);
        wait_idle();
        send_frame(1'b0, 1'b1, 3, 1'b1);
        wait_idle();

        // reset in the middle of unloading
        bp_val = 1'b0;
        rand_frame();
        send_frame(1'b0, 1'b0, 0, 1'b0);
        wait_valid();
        bp_val = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bp_val = 1'b0;
        chk("pre_reset_index", out_index, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_real", out_real, 0);
        chk("midrst_out_imag", out_imag, 0);
        chk("midrst_out_index", out_index, 0);
        chk("midrst_in_ready", in_ready, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("release_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        chk("release_in_ready_high", in_ready, 1);
        bp_val = 1'b1;
        set_frame(20, 20, 20, 20, 0, 0, 0, 0);
        send_frame(1'b0, 1'b0, 0, 1'b0);
        wait_idle();

        // randomized frames under random backpressure
        bp_en = 1'b1;
        for (int f = 0; f < 25; f++) begin
            rand_frame();
            send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        wait_idle();
        bp_en = 1'b0;
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
